c64_bus_decode: RTL

//  Memory-side neighbour of the _6502 core: consumes its address/data/write bus, feeds back di.

---
 rtl/c64_pkg.sv | 44 ++++
 rtl/c64_bus_decode_if.sv | 23 ++
 rtl/c64_port_fade.sv | 34 +++
 rtl/c64_bus_decode.sv | 127 ++++++++++++
 4 files changed

// File: rtl/c64_pkg.sv
// Shared C64 memory-map constants, bank bit positions and read-source select type
// for the bus decoder and its helpers.
package c64_pkg;

    localparam logic [15:0] PORT_DDR_ADDR  = 16'h0000;
    localparam logic [15:0] PORT_DATA_ADDR = 16'h0001;

    localparam logic [15:0] BASIC_BASE  = 16'hA000;
    localparam logic [15:0] IO_BASE     = 16'hD000;
    localparam logic [15:0] KERNAL_BASE = 16'hE000;

    localparam int LORAM_B  = 0;
    localparam int HIRAM_B  = 1;
    localparam int CHAREN_B = 2;

    typedef enum logic [2:0] {
        SRC_RAM,
        SRC_BASIC,
        SRC_KERNAL,
        SRC_CHAR,
        SRC_IO,
        SRC_PORT
    } src_e;

    typedef struct packed {
        logic charen;
        logic hiram;
        logic loram;
    } bank_t;

    // BASIC and KERNAL are 8 KiB windows, the I/O / CHAR window is 4 KiB.
    function automatic logic in_basic(input logic [15:0] ab);
        return ab[15:13] == BASIC_BASE[15:13];
    endfunction

    function automatic logic in_io(input logic [15:0] ab);
        return ab[15:12] == IO_BASE[15:12];
    endfunction

    function automatic logic in_kernal(input logic [15:0] ab);
        return ab[15:13] == KERNAL_BASE[15:13];
    endfunction

endpackage

// File: rtl/c64_bus_decode_if.sv
// CPU-side bus between the 6502 core (master) and the C64 bus decoder (slave).
interface c64_bus_decode_if;

    logic [15:0] cpu_ab;
    logic [7:0]  cpu_do;
    logic        cpu_we;
    logic [7:0]  cpu_di;

    modport master (
        output cpu_ab,
        output cpu_do,
        output cpu_we,
        input  cpu_di
    );

    modport slave (
        input  cpu_ab,
        input  cpu_do,
        input  cpu_we,
        output cpu_di
    );

endinterface

// File: rtl/c64_port_fade.sv
// Models the capacitive hold of an undriven 6510 port bit: the last driven level
// survives FADE_CYCLES cycles after the pin stops being driven, then reads 0.
module c64_port_fade #(
    parameter int                FADE_W      = 16,
    parameter logic [FADE_W-1:0] FADE_CYCLES = FADE_W'(64)
) (
    input  logic clk,
    input  logic reset,
    input  logic drive,
    input  logic level,
    output logic held
);

    localparam logic [FADE_W-1:0] ONE = FADE_W'(1);

    logic [FADE_W-1:0] cnt;

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt  <= '0;
            held <= 1'b0;
        end else if (drive) begin
            cnt  <= FADE_CYCLES;
            held <= level;
        end else if (cnt != '0) begin
            cnt <= cnt - ONE;
            if (cnt == ONE) begin
                held <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/c64_bus_decode.sv
// C64 memory-side bus decoder: 6510 processor port at $0000/$0001, bank switching
// from LORAM/HIRAM/CHAREN and a same-cycle read-data mux for the CPU.
module c64_bus_decode
    import c64_pkg::*;
#(
    parameter int                FADE_W      = 16,
    parameter logic [FADE_W-1:0] FADE_CYCLES = FADE_W'(64)
) (
    input  logic              clk,
    input  logic              reset,
    c64_bus_decode_if.slave   bus,
    output logic [15:0]       ram_addr,
    output logic [7:0]        ram_wdata,
    output logic              ram_we,
    input  logic [7:0]        ram_rdata,
    input  logic [7:0]        basic_rdata,
    input  logic [7:0]        kernal_rdata,
    input  logic [7:0]        char_rdata,
    input  logic [7:0]        io_rdata,
    output logic              io_cs,
    output logic              io_we,
    input  logic [5:0]        port_in,
    output logic [7:0]        port_eff
);

    logic [7:0] ddr;
    logic [7:0] data;
    logic [7:0] ddr_next;
    logic [7:0] data_next;
    logic [1:0] fade_val;
    logic [7:0] pin_level;
    logic       ddr_wr;
    logic       data_wr;
    logic       unused_pins;
    bank_t      bank;
    src_e       src;

    assign ddr_wr  = bus.cpu_we && (bus.cpu_ab == PORT_DDR_ADDR);
    assign data_wr = bus.cpu_we && (bus.cpu_ab == PORT_DATA_ADDR);

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        ddr_next  = ddr;
        data_next = data;
        if (ddr_wr) begin
            ddr_next = bus.cpu_do;
        end
        if (data_wr) begin
            data_next = bus.cpu_do;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ddr  <= 8'h00;
            data <= 8'h00;
        end else begin
            ddr  <= ddr_next;
            data <= data_next;
        end
    end

    // The fade cells see the post-write pin state, so a bit driven on this edge
    // restarts its hold window with the level it is driven to.
    for (genvar i = 0; i < 2; i++) begin : g_fade
        c64_port_fade #(
            .FADE_W      (FADE_W),
            .FADE_CYCLES (FADE_CYCLES)
        ) u_fade (
            .clk   (clk),
            .reset (reset),
            .drive (ddr_next[6+i]),
            .level (data_next[6+i]),
            .held  (fade_val[i])
        );
    end

    // P0..P2 have internal pull-ups, so their external levels never reach the port.
    assign unused_pins = &port_in[2:0];
    assign pin_level   = {fade_val, port_in[5:3], 3'b111};
    assign port_eff    = (ddr & data) | (~ddr & pin_level);

    assign bank.loram  = port_eff[LORAM_B];
    assign bank.hiram  = port_eff[HIRAM_B];
    assign bank.charen = port_eff[CHAREN_B];

    function automatic src_e decode(input logic [15:0] ab, input bank_t bk);
        src_e sel;
        sel = SRC_RAM;
        if (ab == PORT_DDR_ADDR || ab == PORT_DATA_ADDR) begin
            sel = SRC_PORT;
        end else if (in_basic(ab)) begin
            sel = (bk.loram && bk.hiram) ? SRC_BASIC : SRC_RAM;
        end else if (in_io(ab)) begin
            if (!bk.loram && !bk.hiram) begin
                sel = SRC_RAM;
            end else begin
                sel = bk.charen ? SRC_IO : SRC_CHAR;
            end
        end else if (in_kernal(ab)) begin
            sel = bk.hiram ? SRC_KERNAL : SRC_RAM;
        end
        return sel;
    endfunction

    assign src = decode(bus.cpu_ab, bank);

    always_comb begin
        bus.cpu_di = ram_rdata;
        unique case (src)
            SRC_BASIC:  bus.cpu_di = basic_rdata;
            SRC_KERNAL: bus.cpu_di = kernal_rdata;
            SRC_CHAR:   bus.cpu_di = char_rdata;
            SRC_IO:     bus.cpu_di = io_rdata;
            SRC_PORT:   bus.cpu_di = (bus.cpu_ab == PORT_DDR_ADDR) ? ddr : port_eff;
            default:    bus.cpu_di = ram_rdata;
        endcase
    end

    // Writes under ROM land in RAM; only the visible I/O window diverts them.
    assign ram_addr  = bus.cpu_ab;
    assign ram_wdata = bus.cpu_do;
    assign io_cs     = (src == SRC_IO);
    assign io_we     = io_cs && bus.cpu_we;
    assign ram_we    = bus.cpu_we && !io_cs;

endmodule
